// File: rtl/cnn_frame_scheduler.sv
// rtl/cnn_frame_scheduler.sv - one-frame-in-flight scheduler between a pixel source and the CNN pipeline
module cnn_frame_scheduler #(
  parameter int IMG_PIXELS = 784,
  parameter int TIMEOUT    = 4095,
  parameter int TO_BITS    = 16,
  parameter int TAG_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [7:0]          src_data,
  input  logic                src_valid,
  output logic                src_ready,
  output logic [7:0]          cnn_data_in,
  output logic                cnn_valid_in,
  input  logic                cnn_busy,
  input  logic [3:0]          cnn_decision,
  input  logic                cnn_valid_out,
  output logic [3:0]          res_decision,
  output logic [TAG_BITS-1:0] res_tag,
  output logic                res_timeout,
  output logic                res_valid,
  output logic                idle,
  output logic                stray
);

  localparam int PIX_BITS = $clog2(IMG_PIXELS + 1);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [PIX_BITS-1:0] pix_cnt;
  logic [TO_BITS-1:0]  wd_cnt;
  logic [TAG_BITS-1:0] tag;
  logic                hs;
  logic                last_pix;
  logic                wd_expired;
  logic                launch;

  // Handshake and frame-boundary decodes shared by the FSM and datapath
  always_comb begin
    src_ready  = (state == STREAM);
    hs         = src_valid & src_ready;
    last_pix   = hs && (pix_cnt == PIX_BITS'(IMG_PIXELS - 1));
    wd_expired = (wd_cnt == TO_BITS'(TIMEOUT));
    launch     = (state == IDLE) && run && !cnn_busy;
  end

  // Next-state logic; a decision arriving on the expiry cycle still wins
  always_comb begin
    state_nxt = state;
    res_valid = 1'b0;
    idle      = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (launch) state_nxt = STREAM;
      end
      STREAM: begin
        if (last_pix) state_nxt = WAIT;
      end
      WAIT: begin
        if (cnn_valid_out || wd_expired) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Pixel counter restarts at launch; watchdog restarts on the last pixel and runs in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt <= '0;
      wd_cnt  <= '0;
    end else begin
      if (launch)  pix_cnt <= '0;
      else if (hs) pix_cnt <= pix_cnt + PIX_BITS'(1);
      if (last_pix)            wd_cnt <= '0;
      else if (state == WAIT)  wd_cnt <= wd_cnt + TO_BITS'(1);
    end
  end

  // Forward accepted pixels one cycle later; data holds between strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnn_valid_in <= 1'b0;
      cnn_data_in  <= '0;
    end else begin
      cnn_valid_in <= hs;
      if (hs) cnn_data_in <= src_data;
    end
  end

  // Capture the result on leaving WAIT; tag advances once the result has been shown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_decision <= '0;
      res_timeout  <= 1'b0;
      tag          <= '0;
    end else begin
      if (state == WAIT) begin
        if (cnn_valid_out) begin
          res_decision <= cnn_decision;
          res_timeout  <= 1'b0;
        end else if (wd_expired) begin
          res_decision <= '0;
          res_timeout  <= 1'b1;
        end
      end
      if (state == DONE) tag <= tag + TAG_BITS'(1);
    end
  end

  // Sticky flag for decisions the scheduler was not waiting for
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              stray <= 1'b0;
    else if (cnn_valid_out && state != WAIT) stray <= 1'b1;
  end

  assign res_tag = tag;

endmodule

// File: tb/tb_cnn_frame_scheduler.sv
// tb/tb_cnn_frame_scheduler.sv - directed bench for cnn_frame_scheduler
module tb_cnn_frame_scheduler;

  localparam int IMG = 784;
  localparam int TMO = 4095;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [7:0] src_data = 8'd0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [7:0] cnn_data_in;
  logic       cnn_valid_in;
  logic       cnn_busy = 1'b0;
  logic [3:0] cnn_decision = 4'd0;
  logic       cnn_valid_out = 1'b0;
  logic [3:0] res_decision;
  logic [3:0] res_tag;
  logic       res_timeout;
  logic       res_valid;
  logic       idle;
  logic       stray;

  int total = 0;
  int bad = 0;
  logic [7:0] fwd_q[$];
  int res_cnt = 0;

  cnn_frame_scheduler #(.IMG_PIXELS(IMG), .TIMEOUT(TMO), .TO_BITS(16), .TAG_BITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .cnn_data_in(cnn_data_in), .cnn_valid_in(cnn_valid_in), .cnn_busy(cnn_busy),
    .cnn_decision(cnn_decision), .cnn_valid_out(cnn_valid_out),
    .res_decision(res_decision), .res_tag(res_tag), .res_timeout(res_timeout),
    .res_valid(res_valid), .idle(idle), .stray(stray)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnn_valid_in === 1'b1) fwd_q.push_back(cnn_data_in);
    if (res_valid === 1'b1) res_cnt++;
  end

  task automatic stream_px(input int n, input bit gapped, output int rdy_cyc);
    int k = 0;
    int cyc = 0;
    rdy_cyc = 0;
    while (k < n && cyc < 8 * n + 100) begin
      @(negedge clk);
      src_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      src_data  = 8'(k);
      if (src_ready) rdy_cyc++;
      if (src_valid && src_ready) k++;
      cyc++;
    end
    total++;
    if (k !== n) begin bad++; $display("FAIL stream_count got=%0d want=%0d", k, n); end
    @(negedge clk);
    src_valid = 1'b0;
  endtask

  task automatic finish_frame(input int delay, input bit give, input logic [3:0] dec, input logic [3:0] exp_tag);
    int early = 0;
    repeat (delay) begin
      @(negedge clk);
      if (res_valid) early++;
    end
    if (give) begin cnn_decision = dec; cnn_valid_out = 1'b1; end
    @(negedge clk);
    cnn_valid_out = 1'b0;
    total++; if (early !== 0) begin bad++; $display("FAIL res_early got=%0d want=0", early); end
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL res_valid got=%b want=1", res_valid); end
    total++; if (res_tag !== exp_tag) begin bad++; $display("FAIL res_tag got=%0d want=%0d", res_tag, exp_tag); end
    total++; if (res_timeout !== !give) begin bad++; $display("FAIL res_timeout got=%b want=%b", res_timeout, !give); end
    total++; if (res_decision !== (give ? dec : 4'd0)) begin bad++; $display("FAIL res_decision got=%0d want=%0d", res_decision, give ? dec : 4'd0); end
    @(negedge clk);
    total++; if ({res_valid, idle} !== 2'b01) begin bad++; $display("FAIL after_done got=%b want=01", {res_valid, idle}); end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    total++;
    if ({cnn_valid_in, res_valid, res_timeout, stray, src_ready, idle, cnn_data_in, res_decision, res_tag} !== {6'b000001, 16'd0}) begin
      bad++; $display("FAIL reset_values got=%b", {cnn_valid_in, res_valid, res_timeout, stray, src_ready, idle, cnn_data_in, res_decision, res_tag});
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL idle_no_run got=%b want=1", idle); end
  endtask

  task automatic test_nominal;
    int base;
    int rdy;
    int err = 0;
    base = fwd_q.size();
    run = 1'b1;
    stream_px(IMG, 1'b0, rdy);
    total++; if (rdy !== IMG) begin bad++; $display("FAIL b2b_ready_cycles got=%0d want=%0d", rdy, IMG); end
    finish_frame(20, 1'b1, 4'd7, 4'd0);
    total++; if (fwd_q.size() - base !== IMG) begin bad++; $display("FAIL nom_pixel_count got=%0d want=%0d", fwd_q.size() - base, IMG); end
    if (fwd_q.size() - base >= IMG) for (int i = 0; i < IMG; i++) if (fwd_q[base + i] !== 8'(i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL nom_pixel_data got=%0d errors want=0", err); end
    @(negedge clk);
    total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL turnaround got=%b want=1", src_ready); end
  endtask

  task automatic test_gapped;
    int base;
    int rdy;
    int err = 0;
    base = fwd_q.size();
    stream_px(IMG, 1'b1, rdy);
    total++; if (src_ready !== 1'b0) begin bad++; $display("FAIL gap_ready_drop got=%b want=0", src_ready); end
    finish_frame(5, 1'b1, 4'd3, 4'd1);
    total++; if (fwd_q.size() - base !== IMG) begin bad++; $display("FAIL gap_pixel_count got=%0d want=%0d", fwd_q.size() - base, IMG); end
    if (fwd_q.size() - base >= IMG) for (int i = 0; i < IMG; i++) if (fwd_q[base + i] !== 8'(i)) err++;
    total++; if (err !== 0) begin bad++; $display("FAIL gap_pixel_data got=%0d errors want=0", err); end
  endtask

  task automatic test_timeout;
    int rdy;
    stream_px(IMG, 1'b0, rdy);
    finish_frame(TMO, 1'b0, 4'd0, 4'd2);
    run = 1'b0;
    total++; if (stray !== 1'b0) begin bad++; $display("FAIL stray_clear got=%b want=0", stray); end
    cnn_decision = 4'd6;
    cnn_valid_out = 1'b1;
    @(negedge clk);
    cnn_valid_out = 1'b0;
    repeat (3) @(negedge clk);
    total++; if ({stray, idle, res_valid} !== 3'b110) begin bad++; $display("FAIL stray_set got=%b want=110", {stray, idle, res_valid}); end
  endtask

  task automatic test_busy;
    int seen = 0;
    int rdy;
    cnn_busy = 1'b1;
    run = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (src_ready) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL busy_hold got=%0d want=0", seen); end
    cnn_busy = 1'b0;
    @(negedge clk);
    total++; if (src_ready !== 1'b1) begin bad++; $display("FAIL busy_release got=%b want=1", src_ready); end
    stream_px(IMG, 1'b0, rdy);
    finish_frame(10, 1'b1, 4'd9, 4'd3);
  endtask

  task automatic test_reset_mid;
    int rc;
    int rdy;
    int base;
    int err = 0;
    rc = res_cnt;
    stream_px(300, 1'b0, rdy);
    rst_n = 1'b0;
    #1;
    total++;
    if ({cnn_valid_in, res_valid, res_timeout, stray, src_ready, idle, cnn_data_in, res_decision, res_tag} !== {6'b000001, 16'd0}) begin
      bad++; $display("FAIL midreset_values got=%b", {cnn_valid_in, res_valid, res_timeout, stray, src_ready, idle, cnn_data_in, res_decision, res_tag});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    total++; if (res_cnt !== rc) begin bad++; $display("FAIL midreset_no_result got=%0d want=%0d", res_cnt, rc); end
    base = fwd_q.size();
    stream_px(IMG, 1'b0, rdy);
    finish_frame(4, 1'b1, 4'd5, 4'd0);
    if (fwd_q.size() - base >= IMG) for (int i = 0; i < IMG; i++) if (fwd_q[base + i] !== 8'(i)) err++;
    total++; if (fwd_q.size() - base !== IMG || err !== 0) begin bad++; $display("FAIL midreset_frame got=%0d px %0d errors want=%0d px 0 errors", fwd_q.size() - base, err, IMG); end
  endtask

  task automatic test_tag_wrap;
    int rdy;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    for (int f = 0; f < 17; f++) begin
      stream_px(IMG, 1'b0, rdy);
      finish_frame((f == 3) ? TMO : 3 + f, 1'b1, 4'(f + 1), 4'(f));
    end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_gapped;
    test_timeout;
    test_busy;
    test_reset_mid;
    test_tag_wrap;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cnn_frame_scheduler.md
# cnn_frame_scheduler

Frame-level controller in front of the CNN inference pipeline. It accepts a pixel stream from an image source with a valid/ready handshake and forwards exactly one 28×28 frame at a time into the pipeline's `data_in`/`valid_in` port. It then waits for the pipeline's `decision`/`valid_out` and returns a tagged result to the host. A watchdog converts a missing decision into a timeout result, so the host never hangs.

## Interface
- `IMG_PIXELS`, default 784: pixels per frame.
- `TIMEOUT`, default 4095: maximum cycles allowed from the last forwarded pixel to the decision.
- `TO_BITS`, default 16: width of the watchdog counter. Must satisfy TIMEOUT < 2^TO_BITS.
- `TAG_BITS`, default 4: width of the frame tag.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `run`, input, 1: level enable. New frames launch only while it is high.
- `src_data`, input, 8: source pixel.
- `src_valid`, input, 1: source pixel is valid.
- `src_ready`, output, 1: scheduler accepts a pixel this cycle.
- `cnn_data_in`, output, 8: pixel to the pipeline. Registered.
- `cnn_valid_in`, output, 1: pixel strobe to the pipeline. Registered.
- `cnn_busy`, input, 1: pipeline busy, OR of all of its layers.
- `cnn_decision`, input, 4: pipeline class decision.
- `cnn_valid_out`, input, 1: decision strobe.
- `res_decision`, output, 4: result class. Forced to 0 on timeout.
- `res_tag`, output, TAG_BITS: tag of the frame the result belongs to.
- `res_timeout`, output, 1: the result is a watchdog timeout.
- `res_valid`, output, 1: one-cycle result pulse. There is no backpressure.
- `idle`, output, 1: high when the FSM is in IDLE.
- `stray`, output, 1: sticky flag. Set by a `cnn_valid_out` that arrives outside WAIT. Cleared only by reset.

## Operation
- **FSM states:** IDLE, STREAM, WAIT, DONE.
- **IDLE:**
  - `src_ready` is 0.
  - Go to STREAM when `run` is 1 and `cnn_busy` is 0.
  - On that transition, clear the pixel counter.
- **STREAM:**
  - `src_ready` = 1 (combinational on state).
  - Each cycle with `src_valid` & `src_ready`, register `src_data` into `cnn_data_in`, set `cnn_valid_in` to 1, and increment the pixel counter.
  - Cycles without a handshake drive `cnn_valid_in` to 0 and hold `cnn_data_in`.
  - When the accepted pixel is number IMG_PIXELS:
    - go to WAIT;
    - `src_ready` drops in the next cycle;
    - clear the watchdog counter.
  - `run` falling during STREAM does not abort the frame.
- **WAIT:**
  - `src_ready` is 0.
  - The watchdog increments every cycle.
  - `cnn_valid_out` = 1: latch `cnn_decision`, set `res_timeout` to 0, go to DONE.
  - Watchdog reaches TIMEOUT with no decision: set `res_decision` to 0, `res_timeout` to 1, go to DONE.
  - Decision and timeout in the same cycle: the decision wins and `res_timeout` is 0.
- **DONE:**
  - Hold for one cycle with `res_valid` = 1 and `res_tag` = the current tag.
  - Then increment the tag (wraps modulo 2^TAG_BITS) and go to IDLE.
- **Single frame in flight:** a new frame never launches before the previous result is emitted and `cnn_busy` has deasserted.
- **Reset values:** state = IDLE, tag = 0, all counters = 0.
  - Outputs at reset: `cnn_valid_in`, `res_valid`, `res_timeout`, `stray` and `src_ready` are 0; `cnn_data_in`, `res_decision` and `res_tag` are 0; `idle` is 1.
- **Reset mid-frame:** all state is discarded and no partial result is emitted. The frame currently in the pipeline is the integrator's responsibility; the pipeline shares `rst_n`.

## Timing
- **Pixel latency:** a pixel accepted at edge t appears on `cnn_data_in`/`cnn_valid_in` after edge t, so the pipeline samples it at edge t+1.
- **Launch:** `run` & !`cnn_busy` sampled at edge t gives `src_ready` = 1 from t through the final handshake.
- **Back-to-back input:** with `src_valid` held at 1, a frame streams in exactly IMG_PIXELS cycles.
- **Result latency:** `cnn_valid_out` sampled at edge t gives `res_valid` high for the single cycle after edge t.
- **Timeout:** `res_valid` with `res_timeout` = 1 asserts TIMEOUT+1 cycles after the WAIT entry edge.
- **Minimum turnaround** from result to the next `src_ready` is 2 cycles (DONE → IDLE → STREAM), further extended while `cnn_busy` is 1.

## Test plan
- **Nominal frame:** reset, `run` = 1, stream 784 pixels of value k mod 256 with `src_valid` held at 1, model decision 7 at a fixed delay.
  - 784 `cnn_valid_in` pulses carrying the same data in order.
  - One `res_valid` with decision 7, tag 0, `res_timeout` 0.
- **Gapped source:** toggle `src_valid` randomly at 50%.
  - Exactly 784 forwarded pixels, with no duplicates or drops.
  - `src_ready` is 0 after the 784th handshake.
- **Timeout:** suppress `cnn_valid_out`.
  - `res_valid`, `res_timeout` = 1 and `res_decision` = 0 arrive exactly 4096 cycles after WAIT entry.
  - A later `cnn_valid_out` then sets `stray`.
- **Busy gating:** hold `cnn_busy` = 1 in IDLE with `run` = 1.
  - `src_ready` stays 0.
  - `src_ready` rises in the cycle after `cnn_busy` falls.
- **Tag wrap and simultaneity:** run 17 frames, driving `cnn_valid_out` on the timeout cycle in frame 3.
  - Frame 3 reports its decision with `res_timeout` = 0.
  - The tags sequence 0..15, then 0.
- **Reset mid-STREAM:** assert `rst_n` = 0 after 300 pixels.
  - All outputs return to their reset values, with no `res_valid`.
  - The next frame after release carries tag 0.
